// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: maps load/store requests onto a single-port RAM without
// byte enables, running sub-word stores as read-modify-write and aligning/extending loads.
module dmem_access_ctrl #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wren,
    input  logic [31:0]       ram_q
);

    typedef enum logic [1:0] {IDLE, READ, CAPTURE, WRITE} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              is_load_q, is_load_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              accept;
    logic              unused_addr_hi;

    // Upper address bits wrap modulo the RAM size.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    function automatic logic req_illegal(input logic rd, input logic wr,
                                         input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (!(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) bad = 1'b1;
        if (wr && (f3 == F3_BU || f3 == F3_HU))             bad = 1'b1;
        if ((f3 == F3_H || f3 == F3_HU) && off[0])          bad = 1'b1;
        if (f3 == F3_W && off != 2'b00)                     bad = 1'b1;
        if (rd && wr)                                       bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                            input logic [2:0] f3);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = word >> {off, 3'b000};
        case (f3)
            F3_B:    res = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   res = {24'h0, shifted[7:0]};
            F3_H:    res = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   res = {16'h0, shifted[15:0]};
            F3_W:    res = word;
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wd,
                                          input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] res;
        res = word;
        if (f3 == F3_B) begin
            res[{off, 3'b000} +: 8] = wd[7:0];
        end else begin
            res[{off[1], 4'b0000} +: 16] = wd[15:0];
        end
        return res;
    endfunction

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        is_load_d   = is_load_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    ram_addr_d = req_addr[ADDR_W+1:2];
                    off_d      = req_addr[1:0];
                    funct3_d   = req_funct3;
                    wdata_d    = req_wdata;
                    is_load_d  = req_read;
                    if (req_read || req_write) begin
                        if (req_illegal(req_read, req_write, req_funct3, req_addr[1:0])) begin
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                            rsp_rdata_d = '0;
                        end else if (req_write && req_funct3 == F3_W) begin
                            ram_wdata_d = req_wdata;
                            state_d     = WRITE;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: state_d = CAPTURE;
            CAPTURE: begin
                if (is_load_q) begin
                    rsp_rdata_d = extract(ram_q, off_q, funct3_q);
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    ram_wdata_d = merge(ram_q, wdata_q, off_q, funct3_q);
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            off_q       <= '0;
            funct3_q    <= '0;
            is_load_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            is_load_q   <= is_load_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Decoded from state so an asynchronous reset drops the write enable at once.
    assign ram_wren  = (state_q == WRITE);
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a registered-read RAM behind it.
module tb_dmem_access_ctrl;

    localparam int unsigned ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_read, req_write;
    logic [31:0]       req_addr, req_wdata;
    logic [2:0]        req_funct3;
    logic              rsp_valid, rsp_err;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_q;
    logic              ram_wren;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    int          wr_count = 0;
    int          checks = 0;
    int          failures = 0;
    int          wc0;

    dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_addr] <= ram_wdata;
            wr_count      <= wr_count + 1;
        end
        ram_q <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request at a negedge; returns at the negedge of cycle T+1.
    task automatic send(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3);
        req_valid = 1'b1; req_read = rd; req_write = wr;
        req_addr = addr; req_wdata = wd; req_funct3 = f3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    endtask

    task automatic load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] exp);
        send(1'b1, 1'b0, addr, 32'h0, f3);
        chk({tag, "_t1_valid"}, rsp_valid, 0);
        @(negedge clk);
        chk({tag, "_t2_valid"}, rsp_valid, 0);
        @(negedge clk);
        chk({tag, "_t3_valid"}, rsp_valid, 1);
        chk({tag, "_t3_err"}, rsp_err, 0);
        chk({tag, "_rdata"}, rsp_rdata, exp);
    endtask

    task automatic err_req(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [2:0] f3);
        wc0 = wr_count;
        send(rd, wr, addr, 32'hFFFF_FFFF, f3);
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_err"}, rsp_err, 1);
        chk({tag, "_wren"}, ram_wren, 0);
        chk({tag, "_ready"}, req_ready, 1);
        @(negedge clk);
        chk({tag, "_pulse"}, {rsp_valid, rsp_err}, 0);
        chk({tag, "_nowrite"}, wr_count - wc0, 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        rst = 1'b1;
        req_valid = 0; req_read = 0; req_write = 0;
        req_addr = 0; req_wdata = 0; req_funct3 = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_outs", {rsp_valid, rsp_err, ram_wren}, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_rdata", rsp_rdata, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", req_ready, 1);

        // SW 0x10: write at T+1, response at T+2
        wc0 = wr_count;
        send(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010);
        chk("sw_t1_wren", ram_wren, 1);
        chk("sw_t1_addr", ram_addr, 4);
        chk("sw_t1_wdata", ram_wdata, 32'hDEAD_BEEF);
        chk("sw_t1_ready", req_ready, 0);
        chk("sw_t1_valid", rsp_valid, 0);
        @(negedge clk);
        chk("sw_t2_valid", rsp_valid, 1);
        chk("sw_t2_err", rsp_err, 0);
        chk("sw_t2_rdata", rsp_rdata, 0);
        chk("sw_t2_wren", ram_wren, 0);
        chk("sw_writes", wr_count - wc0, 1);

        load("lw10", 32'h10, 3'b010, 32'hDEAD_BEEF);
        load("lb13", 32'h13, 3'b000, 32'hFFFF_FFDE);
        load("lbu13", 32'h13, 3'b100, 32'h0000_00DE);
        load("lh12", 32'h12, 3'b001, 32'hFFFF_DEAD);
        load("lhu10", 32'h10, 3'b101, 32'h0000_BEEF);
        load("lw_wrap", 32'hFFFF_C010, 3'b010, 32'hDEAD_BEEF);

        // SB 0x11: read-modify-write, write at T+3, response at T+4
        wc0 = wr_count;
        send(1'b0, 1'b1, 32'h11, 32'h0000_0055, 3'b000);
        chk("sb_t1_wren", ram_wren, 0);
        chk("sb_t1_ready", req_ready, 0);
        @(negedge clk);
        chk("sb_t2_wren", ram_wren, 0);
        @(negedge clk);
        chk("sb_t3_wren", ram_wren, 1);
        chk("sb_t3_wdata", ram_wdata, 32'hDEAD_55EF);
        chk("sb_t3_addr", ram_addr, 4);
        chk("sb_t3_valid", rsp_valid, 0);
        @(negedge clk);
        chk("sb_t4_valid", rsp_valid, 1);
        chk("sb_t4_rdata", rsp_rdata, 0);
        chk("sb_writes", wr_count - wc0, 1);
        chk("sb_mem", mem[4], 32'hDEAD_55EF);
        load("lbu11", 32'h11, 3'b100, 32'h0000_0055);
        load("lh10", 32'h10, 3'b000 | 3'b001, 32'h0000_55EF);

        // SH into upper half of a zero word
        send(1'b0, 1'b1, 32'h16, 32'h1234_ABCD, 3'b001);
        repeat (3) @(negedge clk);
        chk("sh_mem", mem[5], 32'hABCD_0000);
        load("lh16", 32'h16, 3'b001, 32'hFFFF_ABCD);

        err_req("e_lw_mis", 1'b1, 1'b0, 32'h12, 3'b010);
        err_req("e_sh_mis", 1'b0, 1'b1, 32'h11, 3'b001);
        err_req("e_f3_011", 1'b1, 1'b0, 32'h10, 3'b011);
        err_req("e_sbu", 1'b0, 1'b1, 32'h10, 3'b100);
        err_req("e_rdwr", 1'b1, 1'b1, 32'h10, 3'b010);
        chk("err_mem", mem[4], 32'hDEAD_55EF);

        // Neither read nor write: accepted, no response
        send(1'b0, 1'b0, 32'h20, 32'h0, 3'b010);
        chk("nop_t1", {rsp_valid, ram_wren, req_ready}, 3'b001);
        @(negedge clk);
        chk("nop_t2", rsp_valid, 0);

        // Back-to-back SW then LW with req_valid held
        req_valid = 1; req_read = 0; req_write = 1;
        req_addr = 32'h20; req_wdata = 32'hCAFE_F00D; req_funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_t1_ready", req_ready, 0);
        chk("b2b_t1_wren", ram_wren, 1);
        req_read = 1; req_write = 0;
        @(negedge clk);
        chk("b2b_t2_valid", rsp_valid, 1);
        chk("b2b_t2_ready", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 0; req_read = 0;
        chk("b2b_t3_ready", req_ready, 0);
        @(negedge clk);
        chk("b2b_t4_ready", req_ready, 0);
        chk("b2b_t4_valid", rsp_valid, 0);
        @(negedge clk);
        chk("b2b_t5_valid", rsp_valid, 1);
        chk("b2b_t5_rdata", rsp_rdata, 32'hCAFE_F00D);

        // Reset during CAPTURE of an SH aborts it
        wc0 = wr_count;
        send(1'b0, 1'b1, 32'h18, 32'h0000_7777, 3'b001);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_outs", {rsp_valid, rsp_err, ram_wren, req_ready}, 0);
        chk("abort_addr", ram_addr, 0);
        chk("abort_wdata", ram_wdata, 0);
        chk("abort_rdata", rsp_rdata, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_hold", {rsp_valid, ram_wren}, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_after", {rsp_valid, ram_wren}, 0);
        end
        chk("abort_nowrite", wr_count - wc0, 0);
        chk("abort_mem", mem[6], 0);
        chk("abort_ready", req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
